// File: rtl/key_pulser_array.sv
// Array of independent key channels: synchronise, debounce, then emit one-cycle
// pulses on press and, when enabled, auto-repeat pulses while the key is held.
module key_pulser_array #(
  parameter int N_KEYS          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [N_KEYS-1:0] key_ni,
  input  logic              repeat_en_i,
  output logic [N_KEYS-1:0] pulse_o,
  output logic [N_KEYS-1:0] held_o
);

  localparam int DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT,
    ST_HOLD
  } state_e;

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pressed_s;
    logic [DEB_W-1:0]       deb_q, deb_d;
    logic                   held_q, held_d;
    logic                   rise, fall;
    state_e                 state_q, state_d;
    logic [REP_W-1:0]       rep_q, rep_d;
    logic                   pulse_q, pulse_d;

    // Synchroniser resets to the released level so no press is seen out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync_q <= '1;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], key_ni[gi]};
      end
    end

    assign pressed_s = ~sync_q[SYNC_STAGES-1];

    always_comb begin
      deb_d  = '0;
      held_d = held_q;
      if (pressed_s != held_q) begin
        if (deb_q == DEB_LAST) begin
          held_d = pressed_s;
        end else begin
          deb_d = deb_q + DEB_W'(1);
        end
      end
    end

    // Edges are taken from the next debounced state so pulse and held rise together.
    assign rise = held_d & ~held_q;
    assign fall = ~held_d & held_q;

    always_comb begin
      state_d = state_q;
      rep_d   = rep_q;
      pulse_d = 1'b0;
      if (fall) begin
        state_d = ST_IDLE;
        rep_d   = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rise) begin
              pulse_d = 1'b1;
              rep_d   = '0;
              state_d = repeat_en_i ? ST_DELAY : ST_HOLD;
            end
          end
          ST_DELAY: begin
            if (!repeat_en_i) begin
              state_d = ST_HOLD;
              rep_d   = '0;
            end else if (rep_q == DELAY_LAST) begin
              pulse_d = 1'b1;
              rep_d   = '0;
              state_d = ST_REPEAT;
            end else begin
              rep_d = rep_q + REP_W'(1);
            end
          end
          ST_REPEAT: begin
            if (!repeat_en_i) begin
              state_d = ST_HOLD;
              rep_d   = '0;
            end else if (rep_q == PERIOD_LAST) begin
              pulse_d = 1'b1;
              rep_d   = '0;
            end else begin
              rep_d = rep_q + REP_W'(1);
            end
          end
          ST_HOLD: begin
            rep_d = '0;
          end
          default: begin
            state_d = ST_IDLE;
            rep_d   = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        deb_q   <= '0;
        held_q  <= 1'b0;
        state_q <= ST_IDLE;
        rep_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        deb_q   <= deb_d;
        held_q  <= held_d;
        state_q <= state_d;
        rep_q   <= rep_d;
        pulse_q <= pulse_d;
      end
    end

    assign pulse_o[gi] = pulse_q;
    assign held_o[gi]  = held_q;
  end

endmodule

// File: tb/tb_key_pulser_array.sv
// Directed bench for key_pulser_array with short debounce and repeat timings.
module tb_key_pulser_array;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [3:0] key_ni;
  logic       repeat_en_i;
  logic [3:0] pulse_o;
  logic [3:0] held_o;

  int checks = 0;
  int errors = 0;

  key_pulser_array #(
    .N_KEYS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .key_ni(key_ni),
    .repeat_en_i(repeat_en_i), .pulse_o(pulse_o), .held_o(held_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Release the given keys and expect held to clear after the fifth edge, pulse-free.
  task automatic release_keys(input logic [3:0] mask, input string tag);
    key_ni = key_ni | mask;
    for (int e = 0; e < 8; e++) begin
      tick();
      check({tag, "_rel_pulse"}, pulse_o, 4'b0000);
      check({tag, "_rel_held"}, held_o, (e >= 5) ? 4'b0000 : mask);
    end
  endtask

  initial begin
    rst_ni      = 1'b0;
    key_ni      = 4'b1111;
    repeat_en_i = 1'b0;
    #1;
    check("rst_pulse", pulse_o, 4'b0000);
    check("rst_held", held_o, 4'b0000);
    tick();
    tick();
    rst_ni = 1'b1;
    for (int e = 0; e < 4; e++) begin
      tick();
      check("idle_pulse", pulse_o, 4'b0000);
      check("idle_held", held_o, 4'b0000);
    end
    $display("reset: outputs low during and after reset");

    // Single press, no repeat.
    key_ni[0] = 1'b0;
    for (int e = 0; e < 20; e++) begin
      tick();
      check("t1_pulse", pulse_o, (e == 5) ? 4'b0001 : 4'b0000);
      check("t1_held", held_o, (e >= 5) ? 4'b0001 : 4'b0000);
    end
    release_keys(4'b0001, "t1");
    $display("press key0: one pulse after edge 5, clean release");

    // Glitch shorter than the debounce window.
    for (int e = 0; e < 12; e++) begin
      key_ni[1] = (e < 3) ? 1'b0 : 1'b1;
      tick();
      check("t2_pulse", pulse_o, 4'b0000);
      check("t2_held", held_o, 4'b0000);
    end
    $display("glitch key1: 3-cycle low rejected");

    // Auto-repeat, disabled at edge 22, re-enable ignored during the same hold.
    repeat_en_i = 1'b1;
    key_ni[2]   = 1'b0;
    for (int e = 0; e < 35; e++) begin
      if (e == 22) repeat_en_i = 1'b0;
      if (e == 28) repeat_en_i = 1'b1;
      tick();
      check("t3_pulse", pulse_o,
            (e == 5 || e == 15 || e == 18 || e == 21) ? 4'b0100 : 4'b0000);
      check("t3_held", held_o, (e >= 5) ? 4'b0100 : 4'b0000);
    end
    release_keys(4'b0100, "t3");
    $display("repeat key2: pulses at 5,15,18,21 then hold");

    // Release accepted on the same edge a repeat pulse would fire: release wins.
    key_ni[1] = 1'b0;
    for (int e = 0; e < 30; e++) begin
      if (e == 19) key_ni[1] = 1'b1;
      tick();
      check("t4_pulse", pulse_o,
            (e == 5 || e == 15 || e == 18 || e == 21) ? 4'b0010 : 4'b0000);
      check("t4_held", held_o, (e >= 5 && e < 24) ? 4'b0010 : 4'b0000);
    end
    $display("release vs repeat key1: no pulse at edge 24");

    // Two keys pressed on the same edge.
    repeat_en_i = 1'b0;
    key_ni[0]   = 1'b0;
    key_ni[3]   = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      check("t5_pulse", pulse_o, (e == 5) ? 4'b1001 : 4'b0000);
      check("t5_held", held_o, (e >= 5) ? 4'b1001 : 4'b0000);
    end
    release_keys(4'b1001, "t5");
    $display("dual press key0+key3: single 1001 pulse, clean release");

    // Reset in the middle of repetition, released with the key still down.
    repeat_en_i = 1'b1;
    key_ni[2]   = 1'b0;
    for (int e = 0; e <= 16; e++) begin
      tick();
      check("t6_pulse", pulse_o, (e == 5 || e == 15) ? 4'b0100 : 4'b0000);
      check("t6_held", held_o, (e >= 5) ? 4'b0100 : 4'b0000);
    end
    rst_ni = 1'b0;
    #1;
    check("t6_rst_pulse", pulse_o, 4'b0000);
    check("t6_rst_held", held_o, 4'b0000);
    for (int e = 0; e < 3; e++) begin
      tick();
      check("t6_inrst_pulse", pulse_o, 4'b0000);
      check("t6_inrst_held", held_o, 4'b0000);
    end
    rst_ni = 1'b1;
    for (int e = 0; e < 16; e++) begin
      tick();
      check("t6_post_pulse", pulse_o, (e == 5 || e == 15) ? 4'b0100 : 4'b0000);
      check("t6_post_held", held_o, (e >= 5) ? 4'b0100 : 4'b0000);
    end
    $display("reset mid-repeat key2: press re-detected 5 edges after release");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
